// File: rtl/noc_edge_port_adapter.sv
`default_nettype none
// ============================================================================
// Module : noc_edge_port_adapter
// Brief  : Terminates one mesh router port: send/credit <-> valid/ready on RX
//          and TX, with wormhole dest holding on the TX side.
// Rev    : 1.0  initial release
// ============================================================================
module noc_edge_port_adapter #(
  parameter int FLIT_WIDTH      = 128,
  parameter int DEST_WIDTH      = 6,
  parameter int RX_BUFFER_DEPTH = 4,
  parameter int TX_CREDITS      = 1
) (
  input  logic                  clk_noc,
  input  logic                  rst_n,
  // RX from router
  input  logic [FLIT_WIDTH-1:0] rx_data_in,
  input  logic [DEST_WIDTH-1:0] rx_dest_in,
  input  logic                  rx_is_tail_in,
  input  logic                  rx_send_in,
  output logic                  rx_credit_out,
  // RX valid/ready side
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FLIT_WIDTH-1:0] m_data,
  output logic [DEST_WIDTH-1:0] m_dest,
  output logic                  m_last,
  // TX valid/ready side
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [FLIT_WIDTH-1:0] s_data,
  input  logic [DEST_WIDTH-1:0] s_dest,
  input  logic                  s_last,
  // TX to router
  output logic [FLIT_WIDTH-1:0] tx_data_out,
  output logic [DEST_WIDTH-1:0] tx_dest_out,
  output logic                  tx_is_tail_out,
  output logic                  tx_send_out,
  input  logic                  tx_credit_in,
  // sticky error flags
  output logic                  rx_overflow,
  output logic                  tx_credit_err
);

  localparam int c_PTR_W  = (RX_BUFFER_DEPTH > 1) ? $clog2(RX_BUFFER_DEPTH) : 1;
  localparam int c_CNT_W  = $clog2(RX_BUFFER_DEPTH + 1);
  localparam int c_CRED_W = $clog2(TX_CREDITS + 1);
  localparam logic [c_PTR_W-1:0]  c_LAST_PTR = c_PTR_W'(RX_BUFFER_DEPTH - 1);
  localparam logic [c_CNT_W-1:0]  c_FULL_CNT = c_CNT_W'(RX_BUFFER_DEPTH);
  localparam logic [c_CRED_W-1:0] c_MAX_CRED = c_CRED_W'(TX_CREDITS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } tx_state_t;

  // --------------------------------------------------------------------------
  // RX path: first-word-fall-through FIFO
  // --------------------------------------------------------------------------
  logic [FLIT_WIDTH-1:0] r_fifo_data [RX_BUFFER_DEPTH];
  logic [DEST_WIDTH-1:0] r_fifo_dest [RX_BUFFER_DEPTH];
  logic                  r_fifo_tail [RX_BUFFER_DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_CNT_W-1:0]    r_count;
  logic                  r_rx_credit;
  logic                  r_rx_overflow;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;

  function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] p);
    return (p == c_LAST_PTR) ? '0 : p + c_PTR_W'(1);
  endfunction

  assign m_valid = (r_count != '0);
  assign w_full  = (r_count == c_FULL_CNT);
  assign w_pop   = m_valid && m_ready;
  // A pop in the same cycle frees the slot the incoming flit needs.
  assign w_push  = rx_send_in && (!w_full || w_pop);

  // Outputs gated so the head slot's stale contents never leak while empty.
  assign m_data  = m_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign m_dest  = m_valid ? r_fifo_dest[r_rd_ptr] : '0;
  assign m_last  = m_valid ? r_fifo_tail[r_rd_ptr] : 1'b0;

  assign rx_credit_out = r_rx_credit;
  assign rx_overflow   = r_rx_overflow;

  always_ff @(posedge clk_noc) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= rx_data_in;
      r_fifo_dest[r_wr_ptr] <= rx_dest_in;
      r_fifo_tail[r_wr_ptr] <= rx_is_tail_in;
    end
  end

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_rx_credit   <= 1'b0;
      r_rx_overflow <= 1'b0;
    end else begin
      r_rx_credit <= w_pop;
      if (w_push) r_wr_ptr <= f_next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_next_ptr(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + c_CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - c_CNT_W'(1);
      if (rx_send_in && w_full && !w_pop) r_rx_overflow <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // TX path: credit counter, wormhole FSM, registered flit outputs
  // --------------------------------------------------------------------------
  tx_state_t             r_state;
  tx_state_t             w_state_nxt;
  logic [c_CRED_W-1:0]   r_credits;
  logic [DEST_WIDTH-1:0] r_head_dest;
  logic [FLIT_WIDTH-1:0] r_tx_data;
  logic [DEST_WIDTH-1:0] r_tx_dest;
  logic                  r_tx_tail;
  logic                  r_tx_send;
  logic                  r_tx_credit_err;
  logic                  w_accept;
  logic [DEST_WIDTH-1:0] w_flit_dest;

  assign s_ready  = (r_credits != '0);
  assign w_accept = s_valid && s_ready;

  assign tx_data_out    = r_tx_data;
  assign tx_dest_out    = r_tx_dest;
  assign tx_is_tail_out = r_tx_tail;
  assign tx_send_out    = r_tx_send;
  assign tx_credit_err  = r_tx_credit_err;

  always_comb begin
    w_state_nxt = r_state;
    w_flit_dest = s_dest;
    case (r_state)
      ST_IDLE: if (w_accept && !s_last) w_state_nxt = ST_BODY;
      ST_BODY: begin
        w_flit_dest = r_head_dest;
        if (w_accept && s_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_credits       <= c_MAX_CRED;
      r_head_dest     <= '0;
      r_tx_data       <= '0;
      r_tx_dest       <= '0;
      r_tx_tail       <= 1'b0;
      r_tx_send       <= 1'b0;
      r_tx_credit_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tx_send <= w_accept;
      if (w_accept) begin
        r_tx_data <= s_data;
        r_tx_dest <= w_flit_dest;
        r_tx_tail <= s_last;
        if (r_state == ST_IDLE) r_head_dest <= s_dest;
      end
      if (w_accept && !tx_credit_in) begin
        r_credits <= r_credits - c_CRED_W'(1);
      end else if (tx_credit_in && !w_accept) begin
        if (r_credits == c_MAX_CRED) r_tx_credit_err <= 1'b1;
        else                         r_credits <= r_credits + c_CRED_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_noc_edge_port_adapter.sv
`default_nettype none
// ============================================================================
// Module : tb_noc_edge_port_adapter
// Brief  : Self-checking bench: directed sequences, a TX vector table and a
//          randomized run against a queue-based reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_noc_edge_port_adapter;
  localparam int FW    = 32;
  localparam int DW    = 6;
  localparam int DEPTH = 4;
  localparam int TXC   = 2;

  logic          clk_noc = 1'b0;
  logic          rst_n   = 1'b0;
  logic [FW-1:0] rx_data_in;
  logic [DW-1:0] rx_dest_in;
  logic          rx_is_tail_in, rx_send_in, rx_credit_out;
  logic          m_valid, m_ready, m_last;
  logic [FW-1:0] m_data;
  logic [DW-1:0] m_dest;
  logic          s_valid, s_ready, s_last;
  logic [FW-1:0] s_data;
  logic [DW-1:0] s_dest;
  logic [FW-1:0] tx_data_out;
  logic [DW-1:0] tx_dest_out;
  logic          tx_is_tail_out, tx_send_out, tx_credit_in;
  logic          rx_overflow, tx_credit_err;

  noc_edge_port_adapter #(
    .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .RX_BUFFER_DEPTH(DEPTH), .TX_CREDITS(TXC)
  ) dut (
    .clk_noc(clk_noc), .rst_n(rst_n),
    .rx_data_in(rx_data_in), .rx_dest_in(rx_dest_in), .rx_is_tail_in(rx_is_tail_in),
    .rx_send_in(rx_send_in), .rx_credit_out(rx_credit_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_dest(m_dest), .m_last(m_last),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_dest(s_dest), .s_last(s_last),
    .tx_data_out(tx_data_out), .tx_dest_out(tx_dest_out), .tx_is_tail_out(tx_is_tail_out),
    .tx_send_out(tx_send_out), .tx_credit_in(tx_credit_in),
    .rx_overflow(rx_overflow), .tx_credit_err(tx_credit_err)
  );

  always #5 clk_noc = ~clk_noc;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the RX FIFO as a queue, TX as a credit count plus packet flag.
  typedef struct packed {
    logic [FW-1:0] d;
    logic [DW-1:0] dest;
    logic          tail;
  } flit_t;

  flit_t         rxq[$];
  bit            md_ovf, md_rx_cred, md_in_pkt, md_send, md_ttail, md_err;
  int            md_credits, outstanding;
  logic [DW-1:0] md_head, md_tdest;
  logic [FW-1:0] md_tdata;

  task automatic model_reset();
    rxq.delete();
    md_ovf = 0; md_rx_cred = 0; md_in_pkt = 0; md_send = 0; md_ttail = 0; md_err = 0;
    md_credits = TXC; outstanding = 0; md_head = '0; md_tdest = '0; md_tdata = '0;
  endtask

  task automatic drive_idle();
    rx_send_in = 0; rx_data_in = '0; rx_dest_in = '0; rx_is_tail_in = 0; m_ready = 0;
    s_valid = 0; s_data = '0; s_dest = '0; s_last = 0; tx_credit_in = 0;
  endtask

  // Advance the model with the present inputs, clock once, compare all outputs.
  task automatic cycle();
    bit    pop, full, acc;
    flit_t f;
    pop  = (rxq.size() != 0) && m_ready;
    full = (rxq.size() == DEPTH);
    if (pop) void'(rxq.pop_front());
    if (rx_send_in) begin
      if (!full || pop) begin
        f.d = rx_data_in; f.dest = rx_dest_in; f.tail = rx_is_tail_in;
        rxq.push_back(f);
      end else md_ovf = 1;
    end
    md_rx_cred = pop;
    acc = s_valid && (md_credits > 0);
    md_send = acc;
    if (acc) begin
      md_tdata = s_data;
      md_ttail = s_last;
      if (!md_in_pkt) md_head = s_dest;
      md_tdest  = md_head;
      md_in_pkt = !s_last;
    end
    if (tx_credit_in && !acc && md_credits == TXC) md_err = 1;
    else md_credits = md_credits + (tx_credit_in ? 1 : 0) - (acc ? 1 : 0);
    if (tx_credit_in && outstanding > 0) outstanding--;
    if (acc) outstanding++;

    @(posedge clk_noc); #1;
    chk("m_valid", 64'(m_valid), 64'(rxq.size() != 0));
    if (rxq.size() != 0) begin
      chk("m_data", 64'(m_data), 64'(rxq[0].d));
      chk("m_dest", 64'(m_dest), 64'(rxq[0].dest));
      chk("m_last", 64'(m_last), 64'(rxq[0].tail));
    end
    chk("rx_credit_out", 64'(rx_credit_out), 64'(md_rx_cred));
    chk("rx_overflow",   64'(rx_overflow),   64'(md_ovf));
    chk("s_ready",       64'(s_ready),       64'(md_credits > 0));
    chk("tx_send_out",   64'(tx_send_out),   64'(md_send));
    chk("tx_data_out",   64'(tx_data_out),   64'(md_tdata));
    chk("tx_dest_out",   64'(tx_dest_out),   64'(md_tdest));
    chk("tx_is_tail_out", 64'(tx_is_tail_out), 64'(md_ttail));
    chk("tx_credit_err", 64'(tx_credit_err), 64'(md_err));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " m_valid"},  64'(m_valid),  64'd0);
    chk({tag, " m_data"},   64'(m_data),   64'd0);
    chk({tag, " m_dest"},   64'(m_dest),   64'd0);
    chk({tag, " m_last"},   64'(m_last),   64'd0);
    chk({tag, " rx_credit"}, 64'(rx_credit_out), 64'd0);
    chk({tag, " rx_overflow"}, 64'(rx_overflow), 64'd0);
    chk({tag, " tx_send"},  64'(tx_send_out), 64'd0);
    chk({tag, " tx_data"},  64'(tx_data_out), 64'd0);
    chk({tag, " tx_dest"},  64'(tx_dest_out), 64'd0);
    chk({tag, " tx_tail"},  64'(tx_is_tail_out), 64'd0);
    chk({tag, " tx_credit_err"}, 64'(tx_credit_err), 64'd0);
  endtask

  task automatic reset_pulse();
    drive_idle();
    rst_n = 0;
    repeat (2) @(posedge clk_noc);
    #1;
    rst_n = 1;
    model_reset();
  endtask

  typedef struct {
    logic          s_valid;
    logic [DW-1:0] s_dest;
    logic          s_last;
    logic          cr;
    logic          e_send;
    logic [DW-1:0] e_dest;
    logic          e_tail;
    logic          e_ready;
    logic          e_err;
  } vec_t;

  vec_t tv[10];

  initial begin
    int     nsend, nval;
    flit_t  seen[$];

    // TX wormhole / credit vectors, starting from reset (credits=2, IDLE)
    tv[0] = '{1'b1, 6'd5,  1'b0, 1'b0, 1'b1, 6'd5, 1'b0, 1'b1, 1'b0};
    tv[1] = '{1'b1, 6'd9,  1'b0, 1'b1, 1'b1, 6'd5, 1'b0, 1'b1, 1'b0};
    tv[2] = '{1'b1, 6'd12, 1'b1, 1'b1, 1'b1, 6'd5, 1'b1, 1'b1, 1'b0};
    tv[3] = '{1'b1, 6'd7,  1'b1, 1'b0, 1'b1, 6'd7, 1'b1, 1'b0, 1'b0};
    tv[4] = '{1'b1, 6'd3,  1'b0, 1'b0, 1'b0, 6'd7, 1'b1, 1'b0, 1'b0};
    tv[5] = '{1'b0, 6'd3,  1'b0, 1'b1, 1'b0, 6'd7, 1'b1, 1'b1, 1'b0};
    tv[6] = '{1'b1, 6'd3,  1'b0, 1'b1, 1'b1, 6'd3, 1'b0, 1'b1, 1'b0};
    tv[7] = '{1'b1, 6'd8,  1'b1, 1'b1, 1'b1, 6'd3, 1'b1, 1'b1, 1'b0};
    tv[8] = '{1'b0, 6'd8,  1'b0, 1'b1, 1'b0, 6'd3, 1'b1, 1'b1, 1'b0};
    tv[9] = '{1'b0, 6'd8,  1'b0, 1'b1, 1'b0, 6'd3, 1'b1, 1'b1, 1'b1};

    // ---- reset state ----
    drive_idle();
    model_reset();
    repeat (3) @(posedge clk_noc);
    #1;
    chk_all_zero("in_reset");
    rst_n = 1;
    #1;
    chk("s_ready after reset", 64'(s_ready), 64'd1);
    chk("m_valid after reset", 64'(m_valid), 64'd0);

    // ---- RX basic: 3 back-to-back flits, always ready ----
    m_ready = 1; rx_send_in = 1; rx_data_in = 32'hA0; rx_dest_in = 6'd1; rx_is_tail_in = 0;
    cycle();
    chk("rxb c1 m_valid", 64'(m_valid), 64'd1);
    chk("rxb c1 credit",  64'(rx_credit_out), 64'd0);
    chk("rxb c1 data",    64'(m_data), 64'hA0);
    rx_data_in = 32'hB1; rx_dest_in = 6'd2;
    cycle();
    chk("rxb c2 m_valid", 64'(m_valid), 64'd1);
    chk("rxb c2 credit",  64'(rx_credit_out), 64'd1);
    chk("rxb c2 data",    64'(m_data), 64'hB1);
    rx_data_in = 32'hC2; rx_dest_in = 6'd3; rx_is_tail_in = 1;
    cycle();
    chk("rxb c3 credit",  64'(rx_credit_out), 64'd1);
    chk("rxb c3 data",    64'(m_data), 64'hC2);
    chk("rxb c3 last",    64'(m_last), 64'd1);
    rx_send_in = 0; rx_is_tail_in = 0;
    cycle();
    chk("rxb c4 m_valid", 64'(m_valid), 64'd0);
    chk("rxb c4 credit",  64'(rx_credit_out), 64'd1);
    cycle();
    chk("rxb c5 credit",  64'(rx_credit_out), 64'd0);

    // ---- RX backpressure, full edge, overflow ----
    m_ready = 0; rx_send_in = 1;
    for (int k = 0; k < 4; k++) begin
      rx_data_in = 32'hD0 + 32'(k); rx_dest_in = 6'(k);
      cycle();
      chk("rxbp no overflow", 64'(rx_overflow), 64'd0);
    end
    rx_data_in = 32'hD4; m_ready = 1;
    cycle();
    chk("rx full send+pop overflow", 64'(rx_overflow), 64'd0);
    chk("rx full send+pop head", 64'(m_data), 64'hD1);
    rx_data_in = 32'hD5; m_ready = 0;
    cycle();
    chk("rx overflow set", 64'(rx_overflow), 64'd1);
    rx_send_in = 0; m_ready = 1; nval = 0;
    for (int k = 0; k < 6; k++) begin
      if (m_valid) begin
        flit_t f;
        f.d = m_data; f.dest = m_dest; f.tail = m_last;
        seen.push_back(f);
        nval++;
      end
      cycle();
    end
    chk("rx drained count", 64'(nval), 64'd4);
    if (nval == 4) begin
      chk("rx order 0", 64'(seen[0].d), 64'hD1);
      chk("rx order 1", 64'(seen[1].d), 64'hD2);
      chk("rx order 2", 64'(seen[2].d), 64'hD3);
      chk("rx order 3", 64'(seen[3].d), 64'hD4);
    end
    chk("rx overflow sticky", 64'(rx_overflow), 64'd1);
    m_ready = 0;

    // ---- TX credits: s_valid held with 2 credits ----
    s_valid = 1; s_last = 1; nsend = 0;
    for (int k = 0; k < 3; k++) begin
      s_data = 32'h5000 + 32'(k); s_dest = 6'd4;
      cycle();
      if (tx_send_out) nsend++;
    end
    chk("tx sends with 2 credits", 64'(nsend), 64'd2);
    chk("tx s_ready exhausted", 64'(s_ready), 64'd0);
    tx_credit_in = 1;
    cycle();
    chk("tx s_ready after credit", 64'(s_ready), 64'd1);
    chk("tx no send on credit cycle", 64'(tx_send_out), 64'd0);
    tx_credit_in = 0;
    cycle();
    chk("tx send after credit", 64'(tx_send_out), 64'd1);
    s_valid = 0;
    cycle();

    // ---- TX vector table from a fresh reset ----
    reset_pulse();
    for (int i = 0; i < 10; i++) begin
      s_valid = tv[i].s_valid; s_dest = tv[i].s_dest; s_last = tv[i].s_last;
      tx_credit_in = tv[i].cr; s_data = 32'h1000 + 32'(i);
      cycle();
      chk($sformatf("tv%0d send", i),  64'(tx_send_out),    64'(tv[i].e_send));
      chk($sformatf("tv%0d dest", i),  64'(tx_dest_out),    64'(tv[i].e_dest));
      chk($sformatf("tv%0d tail", i),  64'(tx_is_tail_out), 64'(tv[i].e_tail));
      chk($sformatf("tv%0d ready", i), 64'(s_ready),        64'(tv[i].e_ready));
      chk($sformatf("tv%0d err", i),   64'(tx_credit_err),  64'(tv[i].e_err));
    end

    // ---- reset mid-packet ----
    tx_credit_in = 0;
    s_valid = 1; s_dest = 6'd20; s_last = 0; s_data = 32'h2000;
    rx_send_in = 1; rx_data_in = 32'hEE; m_ready = 0;
    cycle();
    rx_send_in = 0; s_dest = 6'd21; s_data = 32'h2001;
    cycle();
    drive_idle();
    rst_n = 0;
    #1;
    chk_all_zero("mid_pkt_reset");
    repeat (2) @(posedge clk_noc);
    #1;
    rst_n = 1;
    model_reset();
    #1;
    chk("s_ready reloaded", 64'(s_ready), 64'd1);
    s_valid = 1; s_dest = 6'd33; s_last = 0; s_data = 32'h3000;
    cycle();
    chk("post-reset head dest", 64'(tx_dest_out), 64'd33);
    s_valid = 0;

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 1500; n++) begin
      rx_send_in    = 1'($urandom_range(0, 1));
      rx_data_in    = $urandom;
      rx_dest_in    = 6'($urandom_range(0, 63));
      rx_is_tail_in = 1'($urandom_range(0, 1));
      m_ready       = ($urandom_range(0, 9) < 6);
      s_valid       = 1'($urandom_range(0, 1));
      s_data        = $urandom;
      s_dest        = 6'($urandom_range(0, 63));
      s_last        = ($urandom_range(0, 3) == 0);
      tx_credit_in  = (outstanding > 0) && ($urandom_range(0, 1) == 1);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
